// File: rtl/lutram_march_ctrl.sv
// March BIST sequencer for one distributed-RAM instance (sync write, async read).
// Runs W(P) up, R(P)W(N) up, R(N)W(P) down, R(P) up, and reports error statistics.
module lutram_march_ctrl #(
  parameter int unsigned   AW      = 4,
  parameter int unsigned   DW      = 10,
  parameter logic [DW-1:0] PATTERN = 10'h2AA,
  parameter int unsigned   ECW     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [ECW-1:0] err_cnt,
  output logic [AW-1:0]  fail_addr,
  output logic [1:0]     fail_elem,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdat,
  input  logic [DW-1:0]  mem_rdat
);

  typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StDone} state_e;

  localparam logic [AW-1:0]  LastAddr = '1;
  localparam logic [ECW-1:0] ErrMax   = '1;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_d;
  logic            we_d, busy_d, done_d, pass_d;
  logic [DW-1:0]   wdat_d;
  logic [ECW-1:0]  err_d;
  logic [AW-1:0]   faddr_d;
  logic [1:0]      felem_d;
  logic            cmp_en;
  logic [DW-1:0]   exp_dat;
  logic [1:0]      cur_elem;

  function automatic logic [DW-1:0] pat_p(input logic [AW-1:0] a);
    return PATTERN ^ DW'(a);
  endfunction

  function automatic logic [DW-1:0] pat_n(input logic [AW-1:0] a);
    return ~(PATTERN ^ DW'(a));
  endfunction

  // Next-state, next-output and in-cycle compare against the async read data.
  always_comb begin
    state_d  = state_q;
    addr_d   = mem_addr;
    we_d     = 1'b0;
    wdat_d   = mem_wdat;
    busy_d   = busy;
    done_d   = 1'b0;
    pass_d   = pass;
    err_d    = err_cnt;
    faddr_d  = fail_addr;
    felem_d  = fail_elem;
    cmp_en   = 1'b0;
    exp_dat  = '0;
    cur_elem = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StM0;
          addr_d  = '0;
          we_d    = 1'b1;
          wdat_d  = pat_p('0);
          busy_d  = 1'b1;
          err_d   = '0;
          faddr_d = '0;
          felem_d = 2'd0;
          pass_d  = 1'b0;
        end
      end
      StM0: begin
        we_d = 1'b1;
        if (mem_addr == LastAddr) begin
          state_d = StM1;
          addr_d  = '0;
          wdat_d  = pat_n('0);
        end else begin
          addr_d = mem_addr + 1'b1;
          wdat_d = pat_p(mem_addr + 1'b1);
        end
      end
      StM1: begin
        cmp_en   = 1'b1;
        exp_dat  = pat_p(mem_addr);
        cur_elem = 2'd1;
        we_d     = 1'b1;
        if (mem_addr == LastAddr) begin
          state_d = StM2;
          addr_d  = LastAddr;
          wdat_d  = pat_p(LastAddr);
        end else begin
          addr_d = mem_addr + 1'b1;
          wdat_d = pat_n(mem_addr + 1'b1);
        end
      end
      StM2: begin
        cmp_en   = 1'b1;
        exp_dat  = pat_n(mem_addr);
        cur_elem = 2'd2;
        if (mem_addr == '0) begin
          state_d = StM3;
          addr_d  = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = mem_addr - 1'b1;
          wdat_d = pat_p(mem_addr - 1'b1);
        end
      end
      StM3: begin
        cmp_en   = 1'b1;
        exp_dat  = pat_p(mem_addr);
        cur_elem = 2'd3;
        if (mem_addr == LastAddr) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = mem_addr + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // err_cnt==0 doubles as the "no mismatch yet" flag for first-fail capture.
    if (cmp_en && (mem_rdat != exp_dat)) begin
      if (err_cnt == '0) begin
        faddr_d = mem_addr;
        felem_d = cur_elem;
      end
      if (err_cnt != ErrMax) err_d = err_cnt + 1'b1;
    end

    // pass uses the count including the final compare of the run.
    if (state_q == StM3 && mem_addr == LastAddr) pass_d = (err_d == '0);
  end

  // Registered state and outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_elem <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdat  <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_cnt   <= err_d;
      fail_addr <= faddr_d;
      fail_elem <= felem_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdat  <= wdat_d;
    end
  end

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Bench for lutram_march_ctrl: faulty-RAM model, run-level reference model, per-cycle checker.
module tb_lutram_march_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 10;
  localparam int ECW = 4;
  localparam int SAT = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           busy, done, pass, mem_we;
  logic [ECW-1:0] err_cnt;
  logic [AW-1:0]  fail_addr, mem_addr;
  logic [1:0]     fail_elem;
  logic [DW-1:0]  mem_wdat, mem_rdat;

  logic [DW-1:0]  ram [16];

  // Fault modes: 0 none, 1 stuck bit, 2 coupled decode of f_addr/f_alias, 3 inverted reads.
  int fmode = 0, f_addr = 0, f_bit = 0, f_val = 0, f_alias = 0;

  int errors = 0, checks = 0;

  // Cycle index within an accepted run: 0 idle, 1..64 march, 65 done.
  int k = 0;
  bit after_rst = 1'b0, have_res = 1'b0;
  int e_cnt = 0, e_fa = 0, e_fe = 0;
  int wr_cnt = 0;

  lutram_march_ctrl #(.AW(AW), .DW(DW), .PATTERN(10'h2AA), .ECW(ECW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pv(input int a);
    logic [DW-1:0] base;
    base = 10'h2AA;
    return base ^ DW'(a);
  endfunction

  function automatic logic [DW-1:0] nv(input int a);
    return ~pv(a);
  endfunction

  function automatic logic [DW-1:0] frd(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (fmode == 1 && a == f_addr) r[f_bit] = f_val[0];
    if (fmode == 3) r = ~r;
    return r;
  endfunction

  always_comb mem_rdat = frd(ram[mem_addr], int'(mem_addr));

  // RAM write port, including the coupled-address fault.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdat;
      if (fmode == 2 && int'(mem_addr) == f_addr) ram[f_alias[3:0]] <= mem_wdat;
      if (fmode == 2 && int'(mem_addr) == f_alias) ram[f_addr[3:0]] <= mem_wdat;
    end
  end

  // Whole-run reference: March algorithm applied to a model of the faulty RAM.
  function automatic void run_model(output int cnt, output int fa, output int fe);
    logic [DW-1:0] m [16];
    logic [DW-1:0] d;
    int a;
    cnt = 0; fa = 0; fe = 0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 16; i++) begin
        a = (e == 2) ? 15 - i : i;
        if (e > 0 && frd(m[a], a) != ((e == 2) ? nv(a) : pv(a))) begin
          if (cnt == 0) begin fa = a; fe = e; end
          if (cnt < SAT) cnt++;
        end
        if (e < 3) begin
          d = (e == 1) ? nv(a) : pv(a);
          m[a] = d;
          if (fmode == 2 && a == f_addr) m[f_alias] = d;
          if (fmode == 2 && a == f_alias) m[f_addr] = d;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (k=%0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  // Run tracker: which cycle of a run the next cycle is, from the start/rst rules.
  always @(posedge clk) begin
    int c, a, e;
    if (rst) begin
      k         <= 0;
      after_rst <= 1'b1;
      have_res  <= 1'b0;
    end else begin
      after_rst <= 1'b0;
      if (k == 0) begin
        if (start) begin
          run_model(c, a, e);
          e_cnt <= c; e_fa <= a; e_fe <= e;
          k <= 1;
        end
      end else if (k == 65) begin
        k        <= 0;
        have_res <= 1'b1;
      end else begin
        k <= k + 1;
      end
    end
  end

  // Per-cycle compare against the expected sequence.
  always @(negedge clk) begin
    int a;
    bit we;
    logic [DW-1:0] wd;
    if (after_rst) begin
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);           chk("rst_err_cnt", err_cnt, 0);
      chk("rst_fail_addr", fail_addr, 0); chk("rst_fail_elem", fail_elem, 0);
      chk("rst_mem_we", mem_we, 0);       chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdat", mem_wdat, 0);
    end else if (k == 0) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_we", mem_we, 0);
      if (have_res) begin
        chk("hold_err_cnt", err_cnt, e_cnt);
        chk("hold_pass", pass, (e_cnt == 0));
        chk("hold_fail_addr", fail_addr, e_fa);
        chk("hold_fail_elem", fail_elem, e_fe);
      end
    end else if (k <= 64) begin
      if (k <= 16)      begin a = k - 1;  we = 1'b1; wd = pv(a); end
      else if (k <= 32) begin a = k - 17; we = 1'b1; wd = nv(a); end
      else if (k <= 48) begin a = 48 - k; we = 1'b1; wd = pv(a); end
      else              begin a = k - 49; we = 1'b0; wd = '0;    end
      if (k == 1) begin
        wr_cnt = 0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_pass", pass, 0);
        chk("clr_fail_addr", fail_addr, 0);
        chk("clr_fail_elem", fail_elem, 0);
      end
      if (mem_we) wr_cnt++;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_addr", mem_addr, a);
      chk("run_we", mem_we, we);
      if (we) chk("run_wdat", mem_wdat, wd);
    end else begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_we", mem_we, 0);
      chk("done_err_cnt", err_cnt, e_cnt);
      chk("done_pass", pass, (e_cnt == 0));
      chk("done_fail_addr", fail_addr, e_fa);
      chk("done_fail_elem", fail_elem, e_fe);
      chk("done_writes", wr_cnt, 48);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_fault(input int m, input int fa, input int fb, input int fv, input int al);
    fmode = m; f_addr = fa; f_bit = fb; f_val = fv; f_alias = al;
  endtask

  task automatic run(input int m, input int fa, input int fb, input int fv, input int al);
    set_fault(m, fa, fb, fv, al);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(70);
  endtask

  initial begin
    int c, a, e, rc;

    // Hand-computed pins on the reference model itself.
    set_fault(0, 0, 0, 0, 0);
    run_model(c, a, e);
    chk("model_clean_cnt", c, 0);
    set_fault(1, 5, 0, 1, 0);
    run_model(c, a, e);
    chk("model_stuck_cnt", c, 1);
    chk("model_stuck_addr", a, 5);
    chk("model_stuck_elem", e, 2);
    chk("model_stuck_rd", frd(10'h150, 5), 10'h151);
    set_fault(2, 3, 0, 0, 12);
    run_model(c, a, e);
    chk("model_decode_addr", a, 3);
    chk("model_decode_elem", e, 1);
    chk("model_decode_multi", (c > 1), 1);
    set_fault(3, 0, 0, 0, 0);
    run_model(c, a, e);
    chk("model_sat_cnt", c, 15);
    chk("model_sat_addr", a, 0);
    chk("model_sat_elem", e, 1);

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    run(0, 0, 0, 0, 0);
    run(1, 5, 0, 1, 0);
    run(2, 3, 0, 0, 12);
    run(3, 0, 0, 0, 0);

    // Starts during the run (cycle 10) and in DONE (cycle 65) are ignored.
    set_fault(3, 0, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    start = 1'b1; step(1); start = 1'b0;
    step(54);
    start = 1'b1; step(1); start = 1'b0;
    step(5);
    run(0, 0, 0, 0, 0);

    // Reset inside M1 at cycle 30, then a clean rerun.
    set_fault(0, 0, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    step(29);
    rst = 1'b1; step(1); rst = 1'b0;
    step(3);
    run(0, 0, 0, 0, 0);

    // Randomized faults, stray starts and occasional mid-run resets.
    repeat (25) begin
      set_fault($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 9),
                $urandom_range(0, 1), $urandom_range(0, 15));
      rc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : 0;
      start = 1'b1; step(1); start = 1'b0;
      for (int cy = 1; cy <= 72; cy++) begin
        start = (cy <= 65) && (rc == 0 || cy < rc) && ($urandom_range(0, 7) == 0);
        rst   = (cy == rc);
        step(1);
      end
      start = 1'b0;
      rst   = 1'b0;
      step(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
